// File: rtl/flp_iadd_pipe_pkg.sv
// Shared constants for the sign-magnitude adder pipeline and its operand/sum helpers.
// Imported by the pipeline top, the sum sub-block and the bench.
package flp_iadd_pipe_pkg;

    localparam int NUM_STAGES = 2;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_TAGW   = 4;

endpackage

// File: rtl/flp_iadd_pipe_sm_sum.sv
// Combinational sign-magnitude to two's-complement conversion of two operands and their sum.
// Kept separate so wider multi-operand adders can reuse the operand conversion.
module flp_sm_sum
    import flp_iadd_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               sn1,
    input  logic [WIDTH-1:0]   sg1,
    input  logic               sn2,
    input  logic [WIDTH-1:0]   sg2,
    output logic [WIDTH+1:0]   sum
);

    logic [WIDTH+1:0] mag1_ext;
    logic [WIDTH+1:0] mag2_ext;
    logic [WIDTH+1:0] op1;
    logic [WIDTH+1:0] op2;

    assign mag1_ext = {2'b00, sg1};
    assign mag2_ext = {2'b00, sg2};

    // A zero magnitude contributes nothing regardless of its sign bit.
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (sg1 != '0) begin
            op1 = sn1 ? ((~mag1_ext) + {{(WIDTH+1){1'b0}}, 1'b1}) : mag1_ext;
        end
        if (sg2 != '0) begin
            op2 = sn2 ? ((~mag2_ext) + {{(WIDTH+1){1'b0}}, 1'b1}) : mag2_ext;
        end
    end

    assign sum = op1 + op2;

endmodule

// File: rtl/flp_iadd_pipe.sv
// Two-stage pipelined sign-magnitude add/subtract with valid/ready handshake and tag sideband.
// S1 holds the two's-complement sum, S2 holds the presented sign/magnitude/zero result.
module flp_iadd_pipe
    import flp_iadd_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAGW  = DEF_TAGW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_sub,
    input  logic [TAGW-1:0]   i_tag,
    input  logic              i_sn1,
    input  logic [WIDTH-1:0]  i_sg1,
    input  logic              i_sn2,
    input  logic [WIDTH-1:0]  i_sg2,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [TAGW-1:0]   o_tag,
    output logic              o_sn,
    output logic [WIDTH:0]    o_sg,
    output logic              o_zero
);

    logic              sn2_eff;
    logic [WIDTH+1:0]  sum_in;

    logic              s1_v;
    logic [WIDTH+1:0]  s1_sum;
    logic              s1_both_neg;
    logic [TAGW-1:0]   s1_tag;

    logic              s2_load;
    logic              s1_load;

    logic [WIDTH:0]    s1_low;
    logic              res_sn;
    logic [WIDTH:0]    res_sg;
    logic              res_zero;

    assign sn2_eff = i_sn2 ^ i_sub;

    flp_sm_sum #(
        .WIDTH (WIDTH)
    ) u_sm_sum (
        .sn1 (i_sn1),
        .sg1 (i_sg1),
        .sn2 (sn2_eff),
        .sg2 (i_sg2),
        .sum (sum_in)
    );

    assign s2_load = !o_valid || i_ready;
    assign s1_load = !s1_v || s2_load;
    assign o_ready = s1_load;

    // Both-negative flag keeps -0 + -0 negative; every other zero comes out positive.
    assign s1_low   = s1_sum[WIDTH:0];
    assign res_sn   = s1_sum[WIDTH+1] | s1_both_neg;
    assign res_sg   = res_sn ? ((~s1_low) + {{WIDTH{1'b0}}, 1'b1}) : s1_low;
    assign res_zero = (s1_sum == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v        <= 1'b0;
            s1_sum      <= '0;
            s1_both_neg <= 1'b0;
            s1_tag      <= '0;
        end else if (s1_load) begin
            s1_v <= i_valid;
            if (i_valid) begin
                s1_sum      <= sum_in;
                s1_both_neg <= i_sn1 & sn2_eff;
                s1_tag      <= i_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_tag   <= '0;
            o_sn    <= 1'b0;
            o_sg    <= '0;
            o_zero  <= 1'b0;
        end else if (s2_load) begin
            o_valid <= s1_v;
            if (s1_v) begin
                o_tag  <= s1_tag;
                o_sn   <= res_sn;
                o_sg   <= res_sg;
                o_zero <= res_zero;
            end
        end
    end

endmodule
